beat_recorder: RTL and testbench
================================

Name: beat_recorder

Overview:
- Sits directly upstream of rate_divider and drives its 7-bit ascii key input.
- In idle and record modes it passes the live keyboard key code through.
- In record mode it also stores the performance as a list of (key, duration) events, including rests, in an on-chip event memory.
- In play mode it replays the stored events, so rate_divider regenerates the recorded beat.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- TICK_HZ, 100, duration quantum rate (10 ms at defaults).
- DEPTH, 64, event memory entries (power of two).
- DUR_W, 16, duration field width in ticks.

Ports:
- clk  in  1  system clock.
- resetn  in  1  reset; synchronous, active-low.
- ascii_in  in  7  live key code from the keyboard decoder; 0 = no key (rest).
- record_req  in  1  single-cycle pulse: start recording.
- play_req  in  1  single-cycle pulse: start playback.
- stop_req  in  1  single-cycle pulse: end recording or playback.
- ascii_out  out  7  key code to rate_divider.
- is_record  out  1  high while recording.
- playing  out  1  high while playing back.
- full  out  1  memory filled by the last recording.
- count  out  clog2(DEPTH)+1  number of stored events.

Behaviour:
- Reset (resetn=0 at a clk edge): state IDLE; ascii_out=0, is_record=0, playing=0, full=0, count=0; tick counter=0; memory contents are don't-care.
- Input sampling: ascii_in is registered once as key_s. All comparisons use key_s.
- Passthrough: in IDLE and REC, ascii_out <= key_s. Latency from ascii_in to ascii_out is 2 cycles.
- Tick generator: counts 0..CLK_HZ/TICK_HZ-1 and pulses tick for one cycle at the terminal value. It is cleared to 0 on every state entry.
- Request priority: stop_req > record_req > play_req.
  - record_req is ignored in PLAY.
  - play_req is ignored in REC.
  - play_req with count==0 stays in IDLE.
- States: IDLE, REC, P_FETCH, P_HOLD.
- IDLE -> REC on record_req:
  - wptr=0, count=0, full=0.
  - cur_key=key_s, dur=0.
- REC:
  - On each tick, dur increments, saturating at 2^DUR_W-1.
  - When key_s != cur_key: write {cur_key, dur} to mem[wptr]; wptr++; count++; then cur_key=key_s, dur=0. A write and a tick in the same cycle: the tick is credited to the event being written.
  - On stop_req: flush {cur_key, dur} as the final event, then IDLE.
  - When a write makes count==DEPTH: full=1, go to IDLE immediately. A pending stop_req in that same cycle does not cause a second write.
  - is_record=1 throughout.
- IDLE -> P_FETCH on play_req: rptr=0, playing=1.
- P_FETCH: issue synchronous read of mem[rptr] (1-cycle latency). Next cycle: ascii_out=key, rem=dur, go to P_HOLD.
- P_HOLD:
  - Each tick decrements rem.
  - When rem==0 (including dur==0 at load): rptr++.
  - If rptr==count: go to IDLE and set playing=0. Otherwise go to P_FETCH.
  - ascii_out holds the event key during P_FETCH of the following event, so there is no glitch between events.
- stop_req in P_FETCH/P_HOLD: IDLE next cycle, playing=0, ascii_out reverts to passthrough.
- count, full and memory persist across playbacks until the next record_req.
- resetn low mid-record or mid-playback: all outputs return to reset values on that edge. Previously stored events are lost (count=0).

Decomposition:
- Shared package/include holds:
  - ASCII_W=7 and KEY_REST=7'd0.
  - State encodings.
  - Event word layout {key[6:0], dur[DUR_W-1:0]} with field offset constants.
  - Key-code constants shared with rate_divider (A=65, S=83, ... J=74).
- One natural sub-module: beat_event_ram, a single-port synchronous-read RAM, DEPTH x (7+DUR_W), with write enable, address, write data and read data.

Test Plan (CLK_HZ=100, TICK_HZ=10, so tick every 10 cycles; DEPTH=4 unless noted):
- Passthrough: in IDLE, drive ascii_in=65 -> ascii_out=65 two cycles later; is_record=0, playing=0.
- Record three events: record_req; hold 65 for 30 cycles, 0 for 20, 83 for 40; stop_req -> count=3; mem = {65,3},{0,2},{83,4} (±1 tick alignment checked against the tick model).
- Playback: play_req after the previous test -> ascii_out=65 for 3 ticks, 0 for 2 ticks, 83 for 4 ticks; then playing=0 and ascii_out follows ascii_in.
- Full: record 5 key changes with DEPTH=4 -> full=1 and IDLE after the 4th write; count=4; is_record=0 without stop_req.
- Stop and priority: during playback, assert stop_req and record_req in the same cycle -> IDLE, playing=0, no record entry; a play_req with count==0 after reset is ignored.
- Reset mid-record: resetn=0 for 1 cycle during REC -> ascii_out=0, is_record=0, count=0, full=0.
- Saturation: with DUR_W=4, hold one key for 200 cycles -> stored dur=15.

Source files
------------

// File: rtl/beat_recorder_pkg.sv
// Shared definitions for the beat recorder: key codes, FSM states and the
// stored event word layout {key, dur}.
package beat_recorder_pkg;

  localparam int ASCII_W = 7;
  localparam logic [ASCII_W-1:0] KEY_REST = 7'd0;

  // Key codes shared with rate_divider
  localparam logic [ASCII_W-1:0] KEY_A = 7'd65;
  localparam logic [ASCII_W-1:0] KEY_S = 7'd83;
  localparam logic [ASCII_W-1:0] KEY_D = 7'd68;
  localparam logic [ASCII_W-1:0] KEY_F = 7'd70;
  localparam logic [ASCII_W-1:0] KEY_G = 7'd71;
  localparam logic [ASCII_W-1:0] KEY_H = 7'd72;
  localparam logic [ASCII_W-1:0] KEY_J = 7'd74;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REC     = 2'd1,
    ST_P_FETCH = 2'd2,
    ST_P_HOLD  = 2'd3
  } state_t;

  // Event word: duration in the low bits, key code directly above it.
  localparam int DUR_LSB = 0;

  function automatic int key_lsb(input int dur_w);
    return dur_w;
  endfunction

endpackage

// File: rtl/beat_event_ram.sv
// Single-port event memory with synchronous read; a read during a write
// returns the previous contents.
module beat_event_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 23
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/beat_recorder.sv
// Records live key codes as (key, duration) events and replays them into
// rate_divider; passes the live key through when not playing back.
module beat_recorder
  import beat_recorder_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100,
  parameter int DEPTH   = 64,
  parameter int DUR_W   = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [ASCII_W-1:0]       ascii_in,
  input  logic                     record_req,
  input  logic                     play_req,
  input  logic                     stop_req,
  output logic [ASCII_W-1:0]       ascii_out,
  output logic                     is_record,
  output logic                     playing,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TCNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int EW       = ASCII_W + DUR_W;
  localparam int KEY_LSB  = key_lsb(DUR_W);

  state_t              state, state_next;
  logic [ASCII_W-1:0]  key_s;
  logic [TCNT_W-1:0]   tick_cnt;
  logic                tick;
  logic [AW-1:0]       wptr, rptr;
  logic [ASCII_W-1:0]  cur_key;
  logic [DUR_W-1:0]    dur, dur_credit, rem;
  logic                fresh;
  logic                rec_write, write_full, last_event;
  logic                ram_we;
  logic [AW-1:0]       ram_addr;
  logic [EW-1:0]       ram_wdata, ram_rdata;
  logic [ASCII_W-1:0]  rd_key;
  logic [DUR_W-1:0]    rd_dur;

  assign tick       = (tick_cnt == TCNT_W'(TICK_DIV - 1));
  assign dur_credit = (tick && (dur != '1)) ? dur + DUR_W'(1) : dur;
  assign rec_write  = (state == ST_REC) && ((key_s != cur_key) || stop_req);
  assign write_full = rec_write && (count == CW'(DEPTH - 1));
  assign last_event = (({1'b0, rptr} + CW'(1)) == count);
  assign rd_key     = ram_rdata[KEY_LSB +: ASCII_W];
  assign rd_dur     = ram_rdata[DUR_LSB +: DUR_W];

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Next-state logic; stop beats record beats play
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (stop_req)                         state_next = ST_IDLE;
        else if (record_req)                  state_next = ST_REC;
        else if (play_req && (count != '0))   state_next = ST_P_FETCH;
      end
      ST_REC: begin
        if (write_full || stop_req) state_next = ST_IDLE;
      end
      ST_P_FETCH: begin
        if (stop_req) state_next = ST_IDLE;
        else          state_next = ST_P_HOLD;
      end
      ST_P_HOLD: begin
        if (stop_req)                  state_next = ST_IDLE;
        else if (!fresh && rem == '0)  state_next = last_event ? ST_IDLE : ST_P_FETCH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output / memory-control decode
  always_comb begin
    is_record = 1'b0;
    playing   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = rptr;
    ram_wdata = '0;
    ram_wdata[KEY_LSB +: ASCII_W] = cur_key;
    ram_wdata[DUR_LSB +: DUR_W]   = dur_credit;
    case (state)
      ST_REC: begin
        is_record = 1'b1;
        ram_we    = rec_write;
        ram_addr  = wptr;
      end
      ST_P_FETCH, ST_P_HOLD: playing = 1'b1;
      default: ;
    endcase
  end

  // Tick counter restarts on every state change so durations align to entry
  always_ff @(posedge clk) begin
    if (!resetn || (state_next != state) || tick) tick_cnt <= '0;
    else                                          tick_cnt <= tick_cnt + TCNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      key_s     <= KEY_REST;
      ascii_out <= KEY_REST;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      full      <= 1'b0;
      cur_key   <= KEY_REST;
      dur       <= '0;
      rem       <= '0;
      fresh     <= 1'b0;
    end else begin
      key_s <= ascii_in;
      fresh <= 1'b0;
      case (state)
        ST_IDLE: begin
          ascii_out <= key_s;
          if (state_next == ST_REC) begin
            wptr    <= '0;
            count   <= '0;
            full    <= 1'b0;
            cur_key <= key_s;
            dur     <= '0;
          end
          if (state_next == ST_P_FETCH) rptr <= '0;
        end
        ST_REC: begin
          ascii_out <= key_s;
          if (rec_write) begin
            wptr    <= wptr + AW'(1);
            count   <= count + CW'(1);
            full    <= write_full;
            cur_key <= key_s;
            dur     <= '0;
          end else begin
            dur <= dur_credit;
          end
        end
        ST_P_FETCH: begin
          if (stop_req) ascii_out <= key_s;
          else          fresh     <= 1'b1;
        end
        ST_P_HOLD: begin
          // First hold cycle is when the read data lands
          if (stop_req) begin
            ascii_out <= key_s;
          end else if (fresh) begin
            ascii_out <= rd_key;
            rem       <= rd_dur;
          end else if (rem == '0) begin
            rptr <= rptr + AW'(1);
          end else if (tick) begin
            rem <= rem - DUR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  beat_event_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_beat_recorder.sv
// Bench for beat_recorder: events are queued as they are performed and
// matched against the key runs seen on ascii_out during playback.
module tb_beat_recorder;
  import beat_recorder_pkg::*;

  localparam int CLK_HZ  = 100;
  localparam int TICK_HZ = 10;
  localparam int DEPTH   = 4;
  localparam int DUR_W   = 4;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int PERIOD  = CLK_HZ / TICK_HZ;
  localparam int DUR_MAX = (1 << DUR_W) - 1;

  logic               clk = 1'b0;
  logic               resetn = 1'b0;
  logic [ASCII_W-1:0] ascii_in = '0;
  logic               record_req = 1'b0;
  logic               play_req = 1'b0;
  logic               stop_req = 1'b0;
  logic [ASCII_W-1:0] ascii_out;
  logic               is_record;
  logic               playing;
  logic               full;
  logic [CW-1:0]      count;

  logic [ASCII_W+DUR_W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_pushed = 0;

  beat_recorder #(
    .CLK_HZ  (CLK_HZ),
    .TICK_HZ (TICK_HZ),
    .DEPTH   (DEPTH),
    .DUR_W   (DUR_W)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .ascii_in   (ascii_in),
    .record_req (record_req),
    .play_req   (play_req),
    .stop_req   (stop_req),
    .ascii_out  (ascii_out),
    .is_record  (is_record),
    .playing    (playing),
    .full       (full),
    .count      (count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Drivers
  task automatic rec_event(input logic [ASCII_W-1:0] key, input int n, input bit first);
    int d;
    d = n / PERIOD;
    if (d > DUR_MAX) d = DUR_MAX;
    ascii_in = key;
    if (n_pushed < DEPTH) begin
      exp_q.push_back({key, DUR_W'(d)});
      n_pushed++;
    end
    if (first) begin
      cycles(2);
      record_req = 1'b1;
      cycles(1);
      record_req = 1'b0;
      cycles(n - 1);
    end else begin
      cycles(n);
    end
  endtask

  task automatic pulse_stop();
    stop_req = 1'b1;
    cycles(1);
    stop_req = 1'b0;
  endtask

  task automatic close_run(input int key, input int len, input int idle_key);
    logic [ASCII_W+DUR_W-1:0] e;
    if (key < 0 || key == idle_key) return;
    if (exp_q.size() == 0) begin
      check("extra_event", key, -1);
      return;
    end
    e = exp_q.pop_front();
    check("ev_key", key, int'(e[DUR_W +: ASCII_W]));
    check("ev_dur", len / PERIOD, int'(e[0 +: DUR_W]));
  endtask

  // Scoreboard: replay and compare each key run against the expected queue
  task automatic play_and_check(input logic [ASCII_W-1:0] idle_key);
    int cur;
    int len;
    bit done;
    cur = -1;
    len = 0;
    done = 1'b0;
    ascii_in = idle_key;
    cycles(3);
    play_req = 1'b1;
    cycles(1);
    play_req = 1'b0;
    for (int i = 0; i < 800 && !done; i++) begin
      if (playing) begin
        if (int'(ascii_out) == cur) len++;
        else begin
          close_run(cur, len, int'(idle_key));
          cur = int'(ascii_out);
          len = 1;
        end
        cycles(1);
      end else begin
        close_run(cur, len, int'(idle_key));
        done = 1'b1;
      end
    end
    check("play_done", int'(done), 1);
    check("exp_left", exp_q.size(), 0);
    exp_q.delete();
    n_pushed = 0;
  endtask

  initial begin
    // Reset state
    cycles(3);
    check("rst_ascii_out", ascii_out, 0);
    check("rst_is_record", is_record, 0);
    check("rst_playing", playing, 0);
    check("rst_full", full, 0);
    check("rst_count", count, 0);
    resetn = 1'b1;
    cycles(2);

    // play_req with nothing stored is ignored
    play_req = 1'b1;
    cycles(1);
    play_req = 1'b0;
    check("play_empty", playing, 0);

    // Passthrough latency is two cycles
    ascii_in = KEY_A;
    cycles(1);
    check("pass_lat1", ascii_out, 0);
    cycles(1);
    check("pass_lat2", ascii_out, int'(KEY_A));
    check("pass_is_record", is_record, 0);
    check("pass_playing", playing, 0);

    // Record three events including a rest
    rec_event(KEY_A, 30, 1'b1);
    check("rec_is_record", is_record, 1);
    rec_event(KEY_REST, 20, 1'b0);
    rec_event(KEY_S, 40, 1'b0);
    pulse_stop();
    check("rec3_is_record", is_record, 0);
    check("rec3_count", count, 3);
    check("rec3_full", full, 0);

    // Playback, then passthrough again
    play_and_check(KEY_J);
    cycles(2);
    check("post_play_out", ascii_out, int'(KEY_J));
    ascii_in = KEY_H;
    cycles(2);
    check("post_play_pass", ascii_out, int'(KEY_H));

    // Fill memory: the fifth key change ends recording on its own
    rec_event(KEY_A, 10, 1'b1);
    rec_event(KEY_S, 10, 1'b0);
    rec_event(KEY_D, 10, 1'b0);
    rec_event(KEY_F, 10, 1'b0);
    rec_event(KEY_G, 10, 1'b0);
    check("full_flag", full, 1);
    check("full_count", count, DEPTH);
    check("full_is_record", is_record, 0);
    ascii_in = KEY_H;
    cycles(3);
    check("full_count_hold", count, DEPTH);
    play_and_check(KEY_J);

    // stop + record together during playback
    play_req = 1'b1;
    cycles(1);
    play_req = 1'b0;
    cycles(15);
    check("prio_playing_mid", playing, 1);
    stop_req = 1'b1;
    record_req = 1'b1;
    cycles(1);
    stop_req = 1'b0;
    record_req = 1'b0;
    check("prio_playing", playing, 0);
    check("prio_is_record", is_record, 0);
    check("prio_count", count, DEPTH);
    ascii_in = KEY_D;
    cycles(2);
    check("prio_pass", ascii_out, int'(KEY_D));

    // Reset in the middle of a recording
    rec_event(KEY_A, 15, 1'b1);
    check("mid_is_record", is_record, 1);
    exp_q.delete();
    n_pushed = 0;
    resetn = 1'b0;
    cycles(1);
    check("mrst_ascii_out", ascii_out, 0);
    check("mrst_is_record", is_record, 0);
    check("mrst_count", count, 0);
    check("mrst_full", full, 0);
    resetn = 1'b1;
    cycles(2);

    // Duration saturates at the field maximum
    rec_event(KEY_S, 200, 1'b1);
    pulse_stop();
    check("sat_count", count, 1);
    play_and_check(KEY_J);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
